fpa_seq_ctrl: RTL
=================

// Module: fpa_seq_ctrl
// PURPOSE
//  Clocked sequencer for the FP-add datapath: rom_8 operand pair -> adder -> ram_4 result.
//  - On start, walks N_PAIRS operand pairs (ROM words 2k, 2k+1).
//  - Enables the adder for ADD_LAT cycles per pair, then writes the sum to RAM word k.
//  - When finished, raises done and hands the RAM read port to the external address.
// PARAMETERS
//  DW       32  data width (IEEE-754 single)
//  ROM_AW    3  ROM address width; 2*N_PAIRS <= 2**ROM_AW
//  RAM_AW    2  RAM address width; N_PAIRS <= 2**RAM_AW
//  N_PAIRS   4  operand pairs processed per run (>=1)
//  ADD_LAT   2  adder cycles from en high to sum valid (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  start        in   1       run request, sampled in IDLE or DONE
//  ext_ram_addr in   RAM_AW  external RAM read address, used only in DONE
//  adder_sum    in   DW      adder result
//  rom_addr_a   out  ROM_AW  operand-1 ROM address (2k)
//  rom_addr_b   out  ROM_AW  operand-2 ROM address (2k+1)
//  rom_oe       out  1       ROM output enable
//  adder_en     out  1       adder enable
//  ram_addr     out  RAM_AW  RAM address (k when busy, ext_ram_addr in DONE)
//  ram_rw       out  1       1 = write, 0 = read
//  ram_oe       out  1       RAM output enable
//  ram_in       out  DW      RAM write data
//  busy         out  1       run in progress
//  done         out  1       results valid in RAM; level, not pulse
//  err          out  1       sticky NaN/Inf flag (FPA_NAN_CHECK_EN only)
//  err_idx      out  RAM_AW  index of first bad sum (FPA_NAN_CHECK_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; k=0; all outputs 0. ram_addr=0 in reset, then per-state rule.
//  - States: IDLE -> FETCH -> ADD -> WRITE -> (FETCH | DONE).
//  - IDLE: all outputs 0. start=1 at a clock edge -> FETCH, k=0, busy=1.
//  - FETCH (1 cyc): rom_oe=1; rom_addr_a=2k; rom_addr_b=2k+1; held through ADD.
//  - ADD (ADD_LAT cyc): rom_oe=1, adder_en=1; internal counter counts down from ADD_LAT-1.
//  - WRITE (1 cyc):
//    - ram_rw=1, ram_addr=k, ram_in=adder_sum; adder_en=0.
//    - If k==N_PAIRS-1 -> DONE, else k++ -> FETCH.
//  - DONE:
//    - Outputs: busy=0, done=1, ram_rw=0, ram_oe=1, rom_oe=0.
//    - ram_addr = ext_ram_addr (combinational passthrough).
//    - start=1 clears done and re-enters FETCH with k=0.
//  - Timing: per pair = ADD_LAT+2 cycles.
//    - With start seen at edge 0: busy is high cycles 1..N_PAIRS*(ADD_LAT+2).
//    - done rises the following cycle (defaults: busy 1..16, done from 17).
//  - ram_rw is 0 in every state except WRITE, so exactly one RAM write per pair.
//  - Boundaries:
//    - start while busy: ignored.
//    - start held high: one run per DONE visit (re-triggers from DONE).
//    - rst mid-run: immediate IDLE; RAM holds partial results; done stays 0.
//    - k never wraps past N_PAIRS-1.
//    - ram_in is don't-care outside WRITE (drive 0).
// CONFIGURATION
//  FPA_NAN_CHECK_EN defined:
//    - In WRITE, if adder_sum[30:23]==8'hFF: set err=1.
//    - err_idx=k on the first such event only.
//    - err and err_idx clear on rst or on a new start. The write still happens.
//  FPA_NAN_CHECK_EN undefined: err and err_idx tied to 0; no extra logic.
// TESTING
//  1. Defaults; model adder = 2-cycle FP add of rom_8 words; pulse start.
//     -> RAM = {1.25, 13.0, 1.1875, sum(word0,word1)} at k = {1,2,3,0};
//        done at cycle 17; exactly 4 ram_rw pulses.
//  2. Assert rst during ADD of pair 2.
//     -> all outputs 0 next cycle; after restart, full run completes normally.
//  3. start pulsed in cycles 3 and 9 while busy.
//     -> ignored; done still at cycle 17; rom_addr sequence exactly 0/1, 2/3, 4/5, 6/7.
//  4. In DONE, sweep ext_ram_addr 0..3.
//     -> ram_addr follows in the same cycle; ram_rw=0, ram_oe=1;
//        start then drops done within 1 cycle.
//  5. FPA_NAN_CHECK_EN defined; adder returns 32'h7F800000 on pair 1.
//     -> err=1, err_idx=1 after that WRITE; err cleared by the next start.
//  6. ADD_LAT=1, N_PAIRS=2.
//     -> adder_en high exactly 1 cycle per pair; done at cycle 7.

Source files
------------

// File: rtl/fpa_seq_ctrl.sv
// fpa_seq_ctrl: clocked sequencer for the FP-add datapath.
// For each run it walks N_PAIRS operand pairs. Pair k uses ROM words 2k and 2k+1.
// The adder is enabled for ADD_LAT cycles, then the sum is written to RAM word k.
// When the run finishes, done goes high and the RAM read address follows ext_ram_addr.
// Optional feature: define FPA_NAN_CHECK_EN to add a sticky NaN/Inf flag (err/err_idx).
module fpa_seq_ctrl #(
  parameter int DW      = 32,
  parameter int ROM_AW  = 3,
  parameter int RAM_AW  = 2,
  parameter int N_PAIRS = 4,
  parameter int ADD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RAM_AW-1:0] ext_ram_addr,
  input  logic [DW-1:0]     adder_sum,
  output logic [ROM_AW-1:0] rom_addr_a,
  output logic [ROM_AW-1:0] rom_addr_b,
  output logic              rom_oe,
  output logic              adder_en,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rw,
  output logic              ram_oe,
  output logic [DW-1:0]     ram_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [RAM_AW-1:0] err_idx
);

  localparam int LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ADD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] k_q, k_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              last_pair;
  logic              run_req;
  logic [ROM_AW-1:0] k_rom;

  assign last_pair = (k_q == RAM_AW'(N_PAIRS - 1));
  // start is only honoured while the sequencer is not running.
  assign run_req   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign k_rom     = ROM_AW'(k_q);

  // State, pair index and adder-latency counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic: FETCH -> ADD (ADD_LAT cycles) -> WRITE, repeated once per pair.
  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lat_d   = lat_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (run_req) begin
          state_d = S_FETCH;
          k_d     = '0;
        end
      end
      S_FETCH: begin
        state_d = S_ADD;
        lat_d   = LAT_W'(ADD_LAT - 1);
      end
      S_ADD: begin
        if (lat_q == '0) state_d = S_WRITE;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      S_WRITE: begin
        if (last_pair) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          k_d     = k_q + RAM_AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. The outputs depend on the state only.
  // Exceptions: ram_in passes adder_sum through in WRITE, and ram_addr follows ext_ram_addr in DONE.
  always_comb begin
    rom_addr_a = '0;
    rom_addr_b = '0;
    rom_oe     = 1'b0;
    adder_en   = 1'b0;
    ram_addr   = '0;
    ram_rw     = 1'b0;
    ram_oe     = 1'b0;
    ram_in     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        rom_oe     = 1'b1;
        rom_addr_a = {k_rom[ROM_AW-2:0], 1'b0};
        rom_addr_b = {k_rom[ROM_AW-2:0], 1'b1};
        ram_addr   = k_q;
        busy       = 1'b1;
      end
      S_ADD: begin
        rom_oe     = 1'b1;
        adder_en   = 1'b1;
        rom_addr_a = {k_rom[ROM_AW-2:0], 1'b0};
        rom_addr_b = {k_rom[ROM_AW-2:0], 1'b1};
        ram_addr   = k_q;
        busy       = 1'b1;
      end
      S_WRITE: begin
        ram_rw   = 1'b1;
        ram_addr = k_q;
        ram_in   = adder_sum;
        busy     = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        ram_oe   = 1'b1;
        ram_addr = ext_ram_addr;
      end
      default: ;
    endcase
  end

`ifdef FPA_NAN_CHECK_EN
  logic              err_q;
  logic [RAM_AW-1:0] err_idx_q;
  logic              bad_sum;

  // An all-ones exponent means the sum is NaN or Inf.
  assign bad_sum = (state_q == S_WRITE) && (adder_sum[30:23] == 8'hFF);

  // Sticky error flag. Only the first bad sum of a run records its index; a new run clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (run_req) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else if (bad_sum && !err_q) begin
      err_q     <= 1'b1;
      err_idx_q <= k_q;
    end
  end

  assign err     = err_q;
  assign err_idx = err_idx_q;
`else
  assign err     = 1'b0;
  assign err_idx = '0;
`endif

endmodule
